lif_neuron: RTL and testbench



---
 rtl/lif_neuron.sv | 122 ++++++++++++
 tb/tb_lif_neuron.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with a refractory period, fed by one weighted synapse.
// Optional: define ADAPTIVE_THRESH_EN to raise the threshold after each fire, then let it relax.
module lif_neuron #(
    parameter int WIDTH         = 8,
    parameter int THRESHOLD     = 200,
    parameter int LEAK_SHIFT    = 3,
    parameter int REFRAC_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pre_spike,
    input  logic [WIDTH-1:0] weight,
    output logic             post_spike,
    output logic [WIDTH-1:0] membrane,
    output logic             refractory,
    output logic [7:0]       spike_count
);

    localparam int CW = $clog2(REFRAC_CYCLES + 1);
    localparam logic [CW-1:0]  REFRAC_INIT = CW'(REFRAC_CYCLES);
    localparam logic [WIDTH:0] V_MAX       = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] THR         = (WIDTH+1)'(THRESHOLD);

    typedef enum logic {INTEG, REFRAC} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    refrac_cnt, refrac_cnt_next;
    logic [WIDTH-1:0] membrane_next;
    logic             post_next;
    logic [7:0]       count_next;
    logic [WIDTH:0]   v_sum, v_sat, thr_eff;
    logic             fire;

    // One extra bit holds the sum of leaked membrane and weight; subtraction cannot underflow.
    always_comb begin
        v_sum = {1'b0, membrane} - {1'b0, (membrane >> LEAK_SHIFT)}
              + (pre_spike ? {1'b0, weight} : '0);
        v_sat = v_sum[WIDTH] ? V_MAX : v_sum;
        fire  = (state == INTEG) && (v_sat >= thr_eff);
    end

`ifdef ADAPTIVE_THRESH_EN
    localparam logic [WIDTH:0] OFF_MAX  = V_MAX - THR;
    localparam logic [WIDTH:0] OFF_STEP = (WIDTH+1)'(8);

    logic [WIDTH-1:0] offset, offset_next;
    logic [WIDTH:0]   off_inc;

    assign thr_eff = THR + {1'b0, offset};

    // Offset jumps on a fire (capped so thr_eff never exceeds full scale) and relaxes in INTEG.
    always_comb begin
        offset_next = offset;
        off_inc     = {1'b0, offset} + OFF_STEP;
        if (state == INTEG) begin
            if (fire)
                offset_next = (off_inc > OFF_MAX) ? OFF_MAX[WIDTH-1:0] : off_inc[WIDTH-1:0];
            else if (offset != '0)
                offset_next = offset - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            offset <= '0;
        else
            offset <= offset_next;
    end
`else
    assign thr_eff = THR;
`endif

    always_comb begin
        state_next      = state;
        refrac_cnt_next = refrac_cnt;
        membrane_next   = membrane;
        post_next       = 1'b0;
        count_next      = spike_count;
        case (state)
            INTEG: begin
                if (fire) begin
                    membrane_next   = '0;
                    post_next       = 1'b1;
                    count_next      = spike_count + 8'd1;
                    refrac_cnt_next = REFRAC_INIT;
                    state_next      = REFRAC;
                end else begin
                    membrane_next = v_sat[WIDTH-1:0];
                end
            end
            REFRAC: begin
                membrane_next   = '0;
                refrac_cnt_next = refrac_cnt - 1'b1;
                if (refrac_cnt == CW'(1))
                    state_next = INTEG;
            end
            default: begin
                state_next    = INTEG;
                membrane_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= INTEG;
            refrac_cnt  <= '0;
            membrane    <= '0;
            post_spike  <= 1'b0;
            spike_count <= '0;
        end else begin
            state       <= state_next;
            refrac_cnt  <= refrac_cnt_next;
            membrane    <= membrane_next;
            post_spike  <= post_next;
            spike_count <= count_next;
        end
    end

    assign refractory = (state == REFRAC);

endmodule

// File: tb/tb_lif_neuron.sv
// Directed self-checking bench for lif_neuron with default parameters.
module tb_lif_neuron;

    logic       clk = 1'b0;
    logic       rst;
    logic       pre_spike;
    logic [7:0] weight;
    logic       post_spike;
    logic [7:0] membrane;
    logic       refractory;
    logic [7:0] spike_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lif_neuron #(
        .WIDTH(8),
        .THRESHOLD(200),
        .LEAK_SHIFT(3),
        .REFRAC_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pre_spike(pre_spike),
        .weight(weight),
        .post_spike(post_spike),
        .membrane(membrane),
        .refractory(refractory),
        .spike_count(spike_count)
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Drive inputs, let one rising edge sample them, then settle just after the edge.
    task automatic applyStimulus(input logic p, input logic [7:0] w);
        pre_spike = p;
        weight    = w;
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst       = 1'b1;
        pre_spike = 1'b0;
        weight    = 8'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".post"},  post_spike,  0);
        checkOutput({tag, ".mem"},   membrane,    0);
        checkOutput({tag, ".refr"},  refractory,  0);
        checkOutput({tag, ".count"}, spike_count, 0);
    endtask

    initial begin
        int leak_exp[5];
        int pulses;
        leak_exp = '{64, 56, 49, 43, 38};

        rst       = 1'b1;
        pre_spike = 1'b0;
        weight    = 8'd0;
        @(posedge clk);
        #1;
        checkAllZero("reset_init");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'd0);
        checkAllZero("reset_idle");

        // Leak sequence and eventual hold below 2^LEAK_SHIFT
        applyStimulus(1'b1, 8'd64);
        checkOutput("leak0", membrane, leak_exp[0]);
        for (int i = 1; i < 5; i++) begin
            applyStimulus(1'b0, 8'd0);
            checkOutput($sformatf("leak%0d", i), membrane, leak_exp[i]);
            checkOutput($sformatf("leak_post%0d", i), post_spike, 0);
        end
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'd0);
        checkOutput("leak_floor", membrane, 7);
        applyStimulus(1'b1, 8'd0);
        checkOutput("zero_weight_hold", membrane, 7);

        // Threshold boundary: 199 stays, 200 fires
        applyReset();
        applyStimulus(1'b1, 8'd199);
        checkOutput("below_thr_post", post_spike, 0);
        checkOutput("below_thr_mem", membrane, 199);
        applyReset();
        applyStimulus(1'b1, 8'd200);
        checkOutput("at_thr_post", post_spike, 1);

        // Accumulation across two inputs: 150 -> 150-18+100 = 232 fires
        applyReset();
        applyStimulus(1'b1, 8'd150);
        checkOutput("accum_mem", membrane, 150);
        applyStimulus(1'b1, 8'd100);
        checkOutput("accum_fire", post_spike, 1);

        // Single fire from rest and refractory window length
        applyReset();
        applyStimulus(1'b1, 8'd255);
        checkOutput("fire_post", post_spike, 1);
        checkOutput("fire_mem", membrane, 0);
        checkOutput("fire_count", spike_count, 1);
        checkOutput("fire_refr0", refractory, 1);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 8'd0);
            checkOutput($sformatf("fire_post_after%0d", i), post_spike, 0);
            checkOutput($sformatf("fire_refr%0d", i), refractory, (i < 4) ? 1 : 0);
        end

        // Held input: fires every 5 cycles, membrane pinned to 0
        applyReset();
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'd255);
            checkOutput($sformatf("gate_post%0d", i), post_spike, (i % 5 == 0) ? 1 : 0);
            checkOutput($sformatf("gate_refr%0d", i), refractory, (i % 5 != 4) ? 1 : 0);
            checkOutput($sformatf("gate_mem%0d", i), membrane, 0);
            if (post_spike) pulses++;
        end
        checkOutput("gate_pulses", pulses, 4);
        checkOutput("gate_count", spike_count, 4);

        // Asynchronous reset two cycles into the refractory period
        applyReset();
        applyStimulus(1'b1, 8'd255);
        applyStimulus(1'b0, 8'd0);
        applyStimulus(1'b0, 8'd0);
        checkOutput("midref_pre_refr", refractory, 1);
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("midref_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 8'd255);
        checkOutput("midref_refire", post_spike, 1);
        checkOutput("midref_count", spike_count, 1);

        // Pulses of 205 spaced 6 cycles apart
        applyReset();
        applyStimulus(1'b1, 8'd205);
        checkOutput("adapt_first", post_spike, 1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'd0);
        applyStimulus(1'b1, 8'd205);
`ifdef ADAPTIVE_THRESH_EN
        checkOutput("adapt_second", post_spike, 0);
        checkOutput("adapt_second_mem", membrane, 205);
`else
        checkOutput("adapt_second", post_spike, 1);
        checkOutput("adapt_second_count", spike_count, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
